// File: rtl/pc_sequencer_pkg.sv
// Shared RISC-V defines (XLEN codes, reset vector, sequencer FSM encodings) and the package built on them.
// Zero-latency helpers only; no state, no flow control.
`ifndef RISCV_DEFINES_VH
`define RISCV_DEFINES_VH
`define XLEN_32b  2'd1
`define XLEN_64b  2'd2
`define XLEN_128b 2'd3
`define RESET_LO  64'h0000_0000_0000_1000
`define PCS_BOOT  2'd0
`define PCS_RUN   2'd1
`define PCS_PEND  2'd2
`endif

package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = `PCS_BOOT,
        ST_RUN  = `PCS_RUN,
        ST_PEND = `PCS_PEND
    } pcs_state_e;

    localparam logic [63:0] RESET_LO_64 = `RESET_LO;

    // Width code n selects a 2^(n+4)-bit address space.
    function automatic int xlen_width(input logic [1:0] code);
        return 1 << (int'(code) + 4);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer (valid, target, exception flag); one-cycle write latency.
// Load wins over clear so a trap landing on the release cycle still registers.
module pc_redirect_buf #(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_tgt,
    input  logic         i_exc,
    output logic         o_vld,
    output logic [W-1:0] o_tgt,
    output logic         o_exc
);

    logic         vld_q, vld_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic         exc_q, exc_d;

    always_comb begin
        vld_d = vld_q;
        tgt_d = tgt_q;
        exc_d = exc_q;
        if (i_load) begin
            vld_d = 1'b1;
            tgt_d = i_tgt;
            exc_d = i_exc;
        end else if (i_clr) begin
            vld_d = 1'b0;
            exc_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= 1'b0;
            tgt_q <= '0;
            exc_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            tgt_q <= tgt_d;
            exc_q <= exc_d;
        end
    end

    assign o_vld = vld_q;
    assign o_tgt = tgt_q;
    assign o_exc = exc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: zero-latency redirect priority (exc > mret > branch > jump); stalled redirects park in PEND.
// Build option PC_ALIGN_CHECK_EN turns misaligned branch/jump targets into traps and adds o_misalign.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [1:0] XLEN = `XLEN_64b,
    localparam int        W    = xlen_width(XLEN)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_stall_f,
    input  logic [W-1:0] i_pc_cur,
    input  logic         i_exc_req,
    input  logic [W-1:0] i_exc_vec,
    input  logic         i_mret,
    input  logic [W-1:0] i_mepc,
    input  logic         i_br_taken,
    input  logic [W-1:0] i_br_tgt,
    input  logic         i_jmp,
    input  logic [W-1:0] i_jmp_tgt,
    output logic [W-1:0] o_pc_next,
    output logic         o_pc_wr_en,
    output logic         o_flush,
    output logic [15:0]  o_redirect_cnt
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic         o_misalign
`endif
);

    localparam logic [W-1:0] RESET_PC = W'(RESET_LO_64);

    pcs_state_e   state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;

    logic         sel_vld;
    logic         sel_exc;
    logic [W-1:0] sel_tgt;
`ifdef PC_ALIGN_CHECK_EN
    logic         sel_mis;
`endif

    logic         buf_load, buf_clr, load_exc;
    logic [W-1:0] load_tgt;
    logic         buf_vld, buf_exc;
    logic [W-1:0] buf_tgt;

    always_comb begin
        sel_vld = 1'b1;
        sel_exc = 1'b0;
        sel_tgt = i_exc_vec;
`ifdef PC_ALIGN_CHECK_EN
        sel_mis = 1'b0;
`endif
        if (i_exc_req) begin
            sel_exc = 1'b1;
        end else if (i_mret) begin
            sel_tgt = i_mepc;
        end else if (i_br_taken) begin
            sel_tgt = i_br_tgt;
        end else if (i_jmp) begin
            sel_tgt = i_jmp_tgt;
        end else begin
            sel_vld = 1'b0;
        end
`ifdef PC_ALIGN_CHECK_EN
        if (!i_exc_req && !i_mret && (i_br_taken || i_jmp) && (sel_tgt[1:0] != 2'b00)) begin
            sel_tgt = i_exc_vec;
            sel_exc = 1'b1;
            sel_mis = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clk_en) begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (sel_vld && i_stall_f) state_d = ST_PEND;
                ST_PEND: if (!i_stall_f) state_d = ST_RUN;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        o_pc_next  = i_pc_cur + W'(4);
        o_pc_wr_en = 1'b0;
        o_flush    = 1'b0;
        buf_load   = 1'b0;
        buf_clr    = 1'b0;
        load_tgt   = sel_tgt;
        load_exc   = sel_exc;
`ifdef PC_ALIGN_CHECK_EN
        o_misalign = 1'b0;
`endif
        if (i_rst) begin
            o_pc_next = RESET_PC;
        end else if (i_clk_en) begin
            case (state_q)
                ST_BOOT: begin
                    o_pc_next  = RESET_PC;
                    o_pc_wr_en = 1'b1;
                end
                ST_RUN: begin
                    if (sel_vld) begin
                        o_pc_next  = sel_tgt;
                        o_flush    = 1'b1;
                        o_pc_wr_en = !i_stall_f;
                        buf_load   = i_stall_f;
`ifdef PC_ALIGN_CHECK_EN
                        o_misalign = sel_mis;
`endif
                    end else begin
                        o_pc_wr_en = !i_stall_f;
                    end
                end
                ST_PEND: begin
                    o_flush   = 1'b1;
                    o_pc_next = buf_tgt;
                    if (i_stall_f) begin
                        buf_load = i_exc_req;
                        load_tgt = i_exc_vec;
                        load_exc = 1'b1;
                    end else begin
                        // A fresh trap overtakes a parked non-trap redirect; an older parked trap stands.
                        o_pc_wr_en = buf_vld | i_exc_req;
                        buf_clr    = 1'b1;
                        if (i_exc_req && !buf_exc) o_pc_next = i_exc_vec;
                    end
                end
                default: ;
            endcase
        end
    end

    pc_redirect_buf #(.W(W)) u_buf (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (buf_load),
        .i_clr  (buf_clr),
        .i_tgt  (load_tgt),
        .i_exc  (load_exc),
        .o_vld  (buf_vld),
        .o_tgt  (buf_tgt),
        .o_exc  (buf_exc)
    );

    // Only writes that also flush are applied redirects; the boot write is not.
    always_comb begin
        cnt_d = cnt_q;
        if (o_pc_wr_en && o_flush && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus hand sequences for pc_sequencer (64-bit default build, RESET_LO = 0x1000).
module tb_pc_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, clk_en, stall, exc, mret, br, jmp;
    logic [W-1:0] pc_cur, exc_vec, mepc, br_tgt, jmp_tgt;
    logic [W-1:0] pc_next;
    logic         wr_en, flush;
    logic [15:0]  cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clk_en       (clk_en),
        .i_stall_f      (stall),
        .i_pc_cur       (pc_cur),
        .i_exc_req      (exc),
        .i_exc_vec      (exc_vec),
        .i_mret         (mret),
        .i_mepc         (mepc),
        .i_br_taken     (br),
        .i_br_tgt       (br_tgt),
        .i_jmp          (jmp),
        .i_jmp_tgt      (jmp_tgt),
        .o_pc_next      (pc_next),
        .o_pc_wr_en     (wr_en),
        .o_flush        (flush),
        .o_redirect_cnt (cnt)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .o_misalign     (misalign)
`endif
    );

    typedef struct {
        logic         rst, en, stall;
        logic [W-1:0] pc;
        logic         exc, mret, br;
        logic [W-1:0] br_tgt;
        logic         jmp;
        logic [W-1:0] jmp_tgt;
        logic         chk_next;
        logic [W-1:0] exp_next;
        logic         exp_wr, exp_fl;
        logic [15:0]  exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [W-1:0] pc,
                                input logic x, input logic m, input logic b, input logic [W-1:0] bt,
                                input logic j, input logic [W-1:0] jt, input logic cn,
                                input logic [W-1:0] en_, input logic ew, input logic ef, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.en = e; v.stall = s; v.pc = pc;
        v.exc = x; v.mret = m; v.br = b; v.br_tgt = bt; v.jmp = j; v.jmp_tgt = jt;
        v.chk_next = cn; v.exp_next = en_; v.exp_wr = ew; v.exp_fl = ef; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst     = v.rst;
        clk_en  = v.en;
        stall   = v.stall;
        pc_cur  = v.pc;
        exc     = v.exc;
        mret    = v.mret;
        br      = v.br;
        br_tgt  = v.br_tgt;
        jmp     = v.jmp;
        jmp_tgt = v.jmp_tgt;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[$];
        exc_vec = 'h100;
        mepc    = 'h3000;

        //                rst en st pc        exc mret br br_tgt  jmp jmp_tgt chk next     wr fl cnt
        tbl.push_back(mk(1, 1, 0, 'h2000,     0, 0, 0, 0,       0, 0,       1, 'h1000,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h500,      0, 0, 0, 0,       0, 0,       1, 'h1000,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h1000,     0, 0, 0, 0,       0, 0,       1, 'h1004,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h1004,     0, 0, 0, 0,       0, 0,       1, 'h1008,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h1008,     1, 0, 1, 'h2000,  0, 0,       1, 'h100,    1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 'h100,      0, 0, 0, 0,       0, 0,       1, 'h104,    1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 'h104,      0, 1, 1, 'h2000,  1, 'h4000,  1, 'h3000,   1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 'h3000,     0, 0, 1, 'h2000,  1, 'h4000,  1, 'h2000,   1, 1, 2));
        tbl.push_back(mk(0, 1, 0, 'h2000,     0, 0, 0, 0,       1, 'h4000,  1, 'h4000,   1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 'h4000,     0, 0, 0, 0,       1, 'h5000,  0, 0,        0, 0, 4));
        tbl.push_back(mk(0, 1, 1, 'h4000,     0, 0, 0, 0,       0, 0,       0, 0,        0, 0, 4));
        tbl.push_back(mk(0, 1, 0, 'h4000,     0, 0, 0, 0,       0, 0,       1, 'h4004,   1, 0, 4));
        tbl.push_back(mk(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 1, 0,       1, 0, 4));
        tbl.push_back(mk(0, 1, 1, 0,          0, 0, 1, 'h40,    0, 0,       0, 0,        0, 1, 4));
        tbl.push_back(mk(0, 1, 1, 0,          0, 0, 0, 0,       0, 0,       0, 0,        0, 1, 4));
        tbl.push_back(mk(0, 1, 1, 0,          0, 0, 0, 0,       0, 0,       0, 0,        0, 1, 4));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0, 0, 0,       0, 0,       1, 'h40,     1, 1, 4));
        tbl.push_back(mk(0, 1, 0, 'h40,       0, 0, 0, 0,       0, 0,       1, 'h44,     1, 0, 5));
        tbl.push_back(mk(0, 1, 1, 'h44,       0, 0, 0, 0,       1, 'h40,    0, 0,        0, 1, 5));
        tbl.push_back(mk(0, 1, 1, 'h44,       1, 0, 0, 0,       0, 0,       0, 0,        0, 1, 5));
        tbl.push_back(mk(0, 1, 1, 'h44,       0, 1, 0, 0,       0, 0,       0, 0,        0, 1, 5));
        tbl.push_back(mk(0, 1, 0, 'h44,       0, 0, 0, 0,       0, 0,       1, 'h100,    1, 1, 5));
        tbl.push_back(mk(0, 1, 0, 'h100,      0, 0, 0, 0,       0, 0,       1, 'h104,    1, 0, 6));
        tbl.push_back(mk(0, 1, 1, 'h104,      0, 0, 1, 'h80,    0, 0,       0, 0,        0, 1, 6));
        tbl.push_back(mk(1, 1, 1, 'h104,      0, 0, 0, 0,       0, 0,       1, 'h1000,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h104,      0, 0, 0, 0,       0, 0,       0, 0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h104,      0, 0, 0, 0,       0, 0,       1, 'h1000,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h1000,     0, 0, 0, 0,       0, 0,       1, 'h1004,   1, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            if (tbl[i].chk_next) check($sformatf("v%0d pc_next", i), pc_next, tbl[i].exp_next);
            check($sformatf("v%0d wr_en", i), W'(wr_en), W'(tbl[i].exp_wr));
            check($sformatf("v%0d flush", i), W'(flush), W'(tbl[i].exp_fl));
            check($sformatf("v%0d cnt", i), W'(cnt), W'(tbl[i].exp_cnt));
`ifdef PC_ALIGN_CHECK_EN
            check($sformatf("v%0d misalign", i), W'(misalign), '0);
`endif
            step();
        end

        // Counter saturation: one applied jump per cycle, count starts from 0.
        for (int i = 0; i < 70000; i++) begin
            rst = 0; clk_en = 1; stall = 0; exc = 0; mret = 0; br = 0;
            jmp = 1; jmp_tgt = 'h200; pc_cur = 'h200;
            #1;
            if (i == 1 || i == 65534 || i == 65535 || i == 69999)
                check($sformatf("cnt after %0d redirects", i), W'(cnt), W'((i > 65535) ? 65535 : i));
            step();
        end
        jmp = 0;
        #1;
        check("cnt after 70000 redirects", W'(cnt), W'(16'hFFFF));
        check("seq after saturation", pc_next, 'h204);
        step();

`ifdef PC_ALIGN_CHECK_EN
        jmp = 1; jmp_tgt = 'h42; pc_cur = 'h204;
        #1;
        check("misaligned jump pc_next", pc_next, 'h100);
        check("misaligned jump misalign", W'(misalign), W'(1'b1));
        check("misaligned jump flush", W'(flush), W'(1'b1));
        step();
        jmp_tgt = 'h44;
        #1;
        check("aligned jump pc_next", pc_next, 'h44);
        check("aligned jump misalign", W'(misalign), '0);
        step();
        jmp = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
